// File: rtl/memif_master_if.sv
// Master-side bundle of the memif link plus the local source/sink RAM ports.
interface memif_master_if #(
  parameter int WORD_WIDTH = 36,
  parameter int ADDR_WIDTH = 10
);
  localparam int PACKET_WIDTH = WORD_WIDTH + 4;
  localparam int COUNT_WIDTH  = ADDR_WIDTH + 1;

  logic [COUNT_WIDTH-1:0]  src_addr;
  logic [WORD_WIDTH-1:0]   src_data;
  logic [COUNT_WIDTH-1:0]  dst_addr;
  logic [WORD_WIDTH-1:0]   dst_data;
  logic                    dst_wr_enable;
  logic                    link_reset;
  logic                    link_dataReady;
  logic [PACKET_WIDTH-1:0] link_outPacket;
  logic [PACKET_WIDTH-1:0] link_inPacket;

  modport master (
    output src_addr, dst_addr, dst_data, dst_wr_enable,
    output link_reset, link_dataReady, link_outPacket,
    input  src_data, link_inPacket
  );

  modport slave (
    input  src_addr, dst_addr, dst_data, dst_wr_enable,
    input  link_reset, link_dataReady, link_outPacket,
    output src_data, link_inPacket
  );
endinterface

// File: rtl/memif_master.sv
// memif initiator: frames one read/write transaction into slotted packets and
// captures the target's returned words into a local sink RAM.
module memif_master #(
  parameter int WORD_WIDTH   = 36,
  parameter int ADDR_WIDTH   = 10,
  parameter int PACKET_WIDTH = WORD_WIDTH + 4,
  parameter int COUNT_WIDTH  = ADDR_WIDTH + 1,
  parameter int STROBE_GAP   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  rd_base,
  input  logic [ADDR_WIDTH-1:0]  wr_base,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   write_en,
  output logic                   busy,
  output logic                   done,
  output logic                   rx_error,
  memif_master_if.master         bus
);
  localparam int SW = (STROBE_GAP > 0) ? $clog2(STROBE_GAP + 1) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(STROBE_GAP);
  localparam logic [SW-1:0] SLOT_ONE = SW'(1);
  localparam logic [COUNT_WIDTH-1:0] IDX_ONE = COUNT_WIDTH'(1);
  localparam int H  = WORD_WIDTH / 2;
  localparam int PH = PACKET_WIDTH / 2;

  typedef enum logic [1:0] {IDLE, SEND_RD, SEND_WR, SEND_DATA} state_t;

  state_t                  state, state_nxt;
  logic [SW-1:0]           slot, slot_nxt;
  logic [COUNT_WIDTH-1:0]  idx, idx_nxt, idx_inc, cnt_q;
  logic [ADDR_WIDTH-1:0]   rd_q, wr_q;
  logic                    we_q, done_nxt, rx_err_nxt, strobe, cap_en, pkt_ok;
  logic [PACKET_WIDTH-1:0] out_pkt;

  function automatic logic [PACKET_WIDTH-1:0] pack(input logic [WORD_WIDTH-1:0] w);
    return {2'b01, w[WORD_WIDTH-1:H], 2'b10, w[H-1:0]};
  endfunction

  assign idx_inc = idx + IDX_ONE;

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    idx_nxt    = idx;
    done_nxt   = 1'b0;
    rx_err_nxt = rx_error;
    cap_en     = 1'b0;
    strobe     = (state != IDLE) && (slot == LAST_SLOT);
    case (state)
      IDLE: if (start) begin
        state_nxt  = SEND_RD;
        idx_nxt    = '0;
        rx_err_nxt = 1'b0;
      end
      SEND_RD: if (strobe) state_nxt = SEND_WR;
      SEND_WR: begin
        // word 0 comes back on the write-address strobe
        cap_en = strobe && (cnt_q != '0);
        if (strobe) begin
          state_nxt = (cnt_q == '0) ? IDLE : SEND_DATA;
          done_nxt  = (cnt_q == '0);
        end
      end
      SEND_DATA: begin
        // the final strobe's returned word lies past the range and is dropped
        cap_en = strobe && (idx_inc < cnt_q);
        if (strobe) begin
          idx_nxt = idx_inc;
          if (idx_inc == cnt_q) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    slot_nxt = (state == IDLE || strobe) ? '0 : slot + SLOT_ONE;
    if (cap_en && !pkt_ok) rx_err_nxt = 1'b1;
  end

  always_comb begin
    out_pkt = '0;
    case (state)
      SEND_RD:   out_pkt = pack(WORD_WIDTH'(rd_q));
      SEND_WR:   out_pkt = pack(WORD_WIDTH'(wr_q));
      SEND_DATA: out_pkt = we_q ? pack(bus.src_data) : '0;
      default:   out_pkt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      slot     <= '0;
      idx      <= '0;
      done     <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      state    <= state_nxt;
      slot     <= slot_nxt;
      idx      <= idx_nxt;
      done     <= done_nxt;
      rx_error <= rx_err_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      we_q  <= 1'b0;
    end else if (state == IDLE && start) begin
      rd_q  <= rd_base;
      wr_q  <= wr_base;
      cnt_q <= count;
      we_q  <= write_en;
    end
  end

  assign pkt_ok = (bus.link_inPacket[PACKET_WIDTH-1:PACKET_WIDTH-2] == 2'b01) &&
                  (bus.link_inPacket[PH-1:PH-2] == 2'b10);

  assign busy               = (state != IDLE);
  assign bus.link_reset     = (state == IDLE);
  assign bus.link_dataReady = strobe;
  assign bus.link_outPacket = out_pkt;
  assign bus.src_addr       = idx;
  assign bus.dst_wr_enable  = cap_en;
  assign bus.dst_addr       = (state == SEND_DATA) ? idx_inc : '0;
  assign bus.dst_data       = {bus.link_inPacket[PACKET_WIDTH-3:PH], bus.link_inPacket[PH-3:0]};
endmodule
